// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter sharing one UART_TX between
// several byte producers, with per-requester parity and start watchdog.
`timescale 1ns/1ps
module uart_tx_sched #(
  parameter int Data_WD   = 8,
  parameter int NUM_REQ   = 4,
  parameter int START_TMO = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*Data_WD-1:0] req_data,
  input  logic [NUM_REQ-1:0]         req_par_en,
  input  logic [NUM_REQ-1:0]         req_par_typ,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [Data_WD-1:0]         P_DATA,
  output logic                       Data_Valid,
  output logic                       PAR_EN,
  output logic                       PAR_TYP,
  input  logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tmo_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(START_TMO + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win;
  logic [IW:0]   idx;
  logic          found;
  logic          grant;
  logic          tmo_hit;
  logic [CW-1:0] cnt;

  // search starts just after the last winner so it gets lowest priority
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(off);
      if (idx >= (IW+1)'(NUM_REQ))
        idx = idx - (IW+1)'(NUM_REQ);
      if (!found && req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    tmo_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (!busy && found) begin
          grant   = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = WAIT_HI;
      WAIT_HI: begin
        if (busy) begin
          state_n = WAIT_LO;
        end else if (cnt == CW'(START_TMO - 1)) begin
          tmo_hit = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT_LO: begin
        if (!busy)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      req_ack    <= '0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      PAR_EN     <= 1'b0;
      PAR_TYP    <= 1'b0;
      grant_id   <= IW'(NUM_REQ - 1);
      rr_ptr     <= IW'(NUM_REQ - 1);
      tmo_err    <= 1'b0;
      cnt        <= '0;
    end else begin
      req_ack    <= '0;
      Data_Valid <= 1'b0;
      tmo_err    <= tmo_hit;
      if (grant) begin
        P_DATA   <= req_data[win*Data_WD +: Data_WD];
        PAR_EN   <= req_par_en[win];
        PAR_TYP  <= req_par_typ[win];
        grant_id <= win;
        req_ack  <= NUM_REQ'(1) << win;
      end
      if (state == ISSUE) begin
        Data_Valid <= 1'b1;
        rr_ptr     <= grant_id;
        cnt        <= '0;
      end
      if (state == WAIT_HI && !busy)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and randomized checks of the round-robin
// UART_TX scheduler against a transaction-level reference model.
`timescale 1ns/1ps
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TMO  = 4;
  localparam int QD   = 256;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [NREQ-1:0]  req_valid = '0;
  logic [NREQ-1:0]  req_par_en = '0;
  logic [NREQ-1:0]  req_par_typ = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]  req_ack;
  logic [DW-1:0]    P_DATA;
  logic             Data_Valid;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic             tmo_err;
  logic [1:0]       grant_id;
  logic             busy;
  logic             uart_busy = 1'b0;
  logic             ext_busy = 1'b0;

  assign busy = uart_busy | ext_busy;

  uart_tx_sched #(
    .Data_WD  (DW),
    .NUM_REQ  (NREQ),
    .START_TMO(TMO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_par_en (req_par_en),
    .req_par_typ(req_par_typ),
    .req_ack    (req_ack),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .busy       (busy),
    .grant_id   (grant_id),
    .tmo_err    (tmo_err)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  // producer queues: {par_en, par_typ, data}
  logic [9:0] qmem [NREQ][QD];
  int qh [NREQ];
  int qt [NREQ];
  int n_push = 0;

  // UART model and reference-model state
  int   uart_cnt = 0;
  int   uart_len = 11;
  logic uart_en = 1'b1;
  logic rand_len = 1'b0;
  logic chk_gap = 1'b0;
  logic gap_armed = 1'b0;
  int   cyc = 0;
  int   model_last = NREQ - 1;
  int   ack_cyc = -100;
  int   dv_cyc = -100;
  int   tmo_cyc = -100;
  int   frames = 0;
  int   n_dv = 0;
  int   n_tmo = 0;
  int   glog [1024];
  logic [9:0] exp_word = '0;
  logic [9:0] last_word = '0;
  logic [NREQ-1:0] ack_pend = '0;
  logic dv_pend = 1'b0;
  logic [NREQ-1:0] prev_valid = '0;
  logic [NREQ-1:0] prev_pe = '0;
  logic [NREQ-1:0] prev_pt = '0;
  logic [NREQ*DW-1:0] prev_data = '0;
  logic prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ])
        return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic push(input int i, input logic [7:0] d,
                      input logic pe, input logic pt);
    qmem[i][qt[i]] = {pe, pt, d};
    qt[i]++;
    n_push++;
  endtask

  task automatic monitor();
    int w;
    cyc++;
    if (!RST) begin
      model_last = NREQ - 1;
      ack_cyc    = -100;
      dv_cyc     = -100;
      last_word  = '0;
      gap_armed  = 1'b0;
      ack_pend   = '0;
      dv_pend    = 1'b0;
    end else begin
      if (req_ack != '0) begin
        w = rr_pick(model_last, prev_valid);
        check("ack_onehot", 32'(req_ack), (w < 0) ? 32'd0 : (32'd1 << w));
        check("grant_id", 32'(grant_id), 32'(w));
        check("idle_busy", 32'(prev_busy), 32'd0);
        if (chk_gap && gap_armed)
          check("gap", 32'(cyc - ack_cyc), 32'(uart_len + 4));
        gap_armed = chk_gap;
        if (w >= 0) begin
          exp_word = {prev_pe[w], prev_pt[w], prev_data[w*DW +: DW]};
          model_last = w;
        end
        glog[frames] = w;
        ack_pend |= req_ack;
        ack_cyc = cyc;
        frames++;
      end
      if (Data_Valid) begin
        check("dv_lat", 32'(cyc - ack_cyc), 32'd1);
        check("dv_word", 32'({PAR_EN, PAR_TYP, P_DATA}), 32'(exp_word));
        last_word = exp_word;
        dv_cyc = cyc;
        dv_pend = 1'b1;
        n_dv++;
      end else if (busy && dv_cyc >= 0) begin
        check("hold", 32'({PAR_EN, PAR_TYP, P_DATA}), 32'(last_word));
      end
      if (tmo_err) begin
        check("tmo_time", 32'(cyc - dv_cyc), 32'(TMO));
        tmo_cyc = cyc;
        n_tmo++;
      end
    end
    prev_valid = req_valid;
    prev_pe    = req_par_en;
    prev_pt    = req_par_typ;
    prev_data  = req_data;
    prev_busy  = busy;
  endtask

  task automatic drive();
    if (!RST) begin
      uart_cnt = 0;
    end else begin
      if (uart_cnt > 0)
        uart_cnt--;
      if (dv_pend && uart_en)
        uart_cnt = rand_len ? int'($urandom_range(1, 12)) : uart_len;
    end
    dv_pend = 1'b0;
    uart_busy = (uart_cnt > 0);
    for (int i = 0; i < NREQ; i++) begin
      if (ack_pend[i]) begin
        ack_pend[i] = 1'b0;
        qh[i]++;
        req_valid[i] = 1'b0;
      end
      if (!req_valid[i] && qh[i] < qt[i]) begin
        req_data[i*DW +: DW] = qmem[i][qh[i]][7:0];
        req_par_en[i]  = qmem[i][qh[i]][9];
        req_par_typ[i] = qmem[i][qh[i]][8];
        req_valid[i]   = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
    drive();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      tick();
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames < target && n < budget) begin
      tick();
      n++;
    end
    check("wait_frames", 32'(frames >= target), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_ack"}, 32'(req_ack), 32'd0);
    check({tag, "_pdata"}, 32'(P_DATA), 32'd0);
    check({tag, "_dv"}, 32'(Data_Valid), 32'd0);
    check({tag, "_paren"}, 32'(PAR_EN), 32'd0);
    check({tag, "_partyp"}, 32'(PAR_TYP), 32'd0);
    check({tag, "_gid"}, 32'(grant_id), 32'(NREQ - 1));
    check({tag, "_tmo"}, 32'(tmo_err), 32'd0);
  endtask

  initial begin
    int f0;
    int d0;
    int t0;
    int c0;
    int r;
    for (int i = 0; i < NREQ; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end

    // all requesters valid out of reset, requester 0 has two bytes
    for (int i = 0; i < NREQ; i++)
      push(i, 8'hA0 + 8'(i), 1'($urandom), 1'($urandom));
    push(0, 8'hA4, 1'($urandom), 1'($urandom));
    idle(3);
    chk_reset("rst");
    RST = 1'b1;
    uart_len = 11;
    gap_armed = 1'b0;
    chk_gap = 1'b1;
    wait_frames(5, 200);
    check("order0", 32'(glog[0]), 32'd0);
    check("order1", 32'(glog[1]), 32'd1);
    check("order2", 32'(glog[2]), 32'd2);
    check("order3", 32'(glog[3]), 32'd3);
    check("order4", 32'(glog[4]), 32'd0);
    chk_gap = 1'b0;
    idle(20);

    // single requester with parity, served back-to-back
    gap_armed = 1'b0;
    chk_gap = 1'b1;
    f0 = frames;
    for (int k = 0; k < 3; k++)
      push(2, 8'h5A, 1'b1, 1'b1);
    wait_frames(f0 + 3, 100);
    idle(2);
    check("s3_word", 32'({PAR_EN, PAR_TYP, P_DATA}), 32'h35A);
    check("s3_gid", 32'(grant_id), 32'd2);
    chk_gap = 1'b0;
    idle(20);

    // UART never starts: watchdog fires, next request still served
    uart_en = 1'b0;
    t0 = n_tmo;
    f0 = frames;
    push(0, 8'($urandom), 1'($urandom), 1'($urandom));
    push(3, 8'($urandom), 1'($urandom), 1'($urandom));
    r = 0;
    while (n_tmo == t0 && r < 30) begin
      tick();
      r++;
    end
    uart_en = 1'b1;
    check("tmo_seen", 32'(n_tmo - t0), 32'd1);
    wait_frames(f0 + 2, 20);
    check("tmo_regrant", 32'(ack_cyc - tmo_cyc), 32'd1);
    idle(20);
    check("tmo_once", 32'(n_tmo - t0), 32'd1);

    // async reset while a frame is on the line and req 1 waits
    f0 = frames;
    push(0, 8'($urandom), 1'($urandom), 1'($urandom));
    wait_frames(f0 + 1, 20);
    push(1, 8'($urandom), 1'($urandom), 1'($urandom));
    idle(6);
    #2;
    RST = 1'b0;
    #1;
    chk_reset("arst");
    idle(2);
    RST = 1'b1;
    f0 = frames;
    wait_frames(f0 + 1, 20);
    check("rst_regrant", 32'(grant_id), 32'd1);
    idle(20);

    // foreign frame on the line blocks any grant
    ext_busy = 1'b1;
    f0 = frames;
    d0 = n_dv;
    push(3, 8'($urandom), 1'($urandom), 1'($urandom));
    idle(12);
    check("fb_ack", 32'(frames), 32'(f0));
    check("fb_dv", 32'(n_dv), 32'(d0));
    ext_busy = 1'b0;
    c0 = cyc;
    wait_frames(f0 + 1, 10);
    check("fb_lat", 32'(ack_cyc - c0), 32'd2);
    check("fb_gid", 32'(grant_id), 32'd3);
    idle(20);

    // randomized traffic with random UART frame lengths
    rand_len = 1'b1;
    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        r = int'($urandom_range(0, NREQ - 1));
        if (qt[r] - qh[r] < 3 && qt[r] < QD)
          push(r, 8'($urandom), 1'($urandom), 1'($urandom));
      end
      tick();
    end
    wait_frames(n_push, 4000);
    idle(20);
    check("drain_dv", 32'(n_dv), 32'(frames));
    check("tmo_total", 32'(n_tmo), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
